// File: rtl/serial_rx.sv
// 8N1 serial receiver: two-flop synchroniser, falling-edge start detection,
// mid-bit sampling, and a one-cycle valid / frame_err strobe per frame.
module serial_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          ferr_reg, ferr_next;

  logic rx_meta, rx_s, rx_prev;

  // Synchroniser and edge-history flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_prev && !rx_s) begin
          state_next = START;
        end
      end
      START: begin
        // Half a bit in: the line must still be low or it was a glitch.
        if (cnt_reg == HALF) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    data      = data_reg;
    valid     = valid_reg;
    frame_err = ferr_reg;
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: frames, back-to-back, false start, framing
// error, break line and reset in the middle of a frame.
module tb_serial_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int vcnt = 0;
  int fcnt = 0;
  int bcnt = 0;
  int both_cnt = 0;
  logic [7:0] vdata [16];
  int         vcyc  [16];
  int t0;
  int vbase, fbase, bbase;
  logic [9:0] frame;

  serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobes are logged against the next rising edge, i.e. the edge that captures them.
  always @(negedge clk) begin
    if (valid) begin
      if (vcnt < 16) begin
        vdata[vcnt] <= data;
        vcyc[vcnt]  <= cyc + 1;
      end
      vcnt <= vcnt + 1;
    end
    if (frame_err) fcnt <= fcnt + 1;
    if (busy) bcnt <= bcnt + 1;
    if (valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is aligned 1 ns after a rising edge; the next edge is T0.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    t0 = cyc + 1;
    $display("send byte 0x%02h stop=%0b T0=%0d", b, stop_bit, t0);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      idle_cycles(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic mark();
    vbase = vcnt;
    fbase = fcnt;
    bbase = bcnt;
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(20);

    // Single byte
    mark();
    send_frame(8'hA5, 1'b1);
    idle_cycles(4);
    check("a5_valid_cnt", vcnt - vbase, 32'd1);
    check("a5_latency", vcyc[vbase] - t0, 32'd156);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_ferr_cnt", fcnt - fbase, 32'd0);
    check("a5_busy_cycles", bcnt - bbase, 32'd153);

    // Back-to-back 0x00 then 0xFF
    mark();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_cycles(4);
    check("b2b_valid_cnt", vcnt - vbase, 32'd2);
    check("b2b_spacing", vcyc[vbase + 1] - vcyc[vbase], 32'd160);
    check("b2b_data0", {24'd0, vdata[vbase]}, 32'h00);
    check("b2b_data1", {24'd0, vdata[vbase + 1]}, 32'hFF);

    // False start: 4 low cycles
    mark();
    $display("false start: rx low 4 cycles at T0=%0d", cyc + 1);
    rx = 1'b0;
    idle_cycles(4);
    rx = 1'b1;
    idle_cycles(30);
    check("fs_busy_cycles", bcnt - bbase, 32'd9);
    check("fs_valid_cnt", vcnt - vbase, 32'd0);
    check("fs_ferr_cnt", fcnt - fbase, 32'd0);
    check("fs_data", {24'd0, data}, 32'hFF);
    mark();
    send_frame(8'h3C, 1'b1);
    idle_cycles(4);
    check("3c_valid_cnt", vcnt - vbase, 32'd1);
    check("3c_data", {24'd0, data}, 32'h3C);

    // Framing error
    send_frame(8'h5A, 1'b1);
    idle_cycles(4);
    check("5a_data", {24'd0, data}, 32'h5A);
    mark();
    send_frame(8'h77, 1'b0);
    idle_cycles(20);
    check("fe_ferr_cnt", fcnt - fbase, 32'd1);
    check("fe_valid_cnt", vcnt - vbase, 32'd0);
    check("fe_data", {24'd0, data}, 32'h5A);

    // Break: line held low for 500 cycles
    mark();
    $display("break: rx low 500 cycles at T0=%0d", cyc + 1);
    rx = 1'b0;
    idle_cycles(500);
    check("brk_ferr_cnt", fcnt - fbase, 32'd1);
    check("brk_valid_cnt", vcnt - vbase, 32'd0);
    check("brk_busy_cycles", bcnt - bbase, 32'd153);
    rx = 1'b1;
    idle_cycles(16);
    mark();
    send_frame(8'hC3, 1'b1);
    idle_cycles(4);
    check("c3_valid_cnt", vcnt - vbase, 32'd1);
    check("c3_data", {24'd0, data}, 32'hC3);

    // Reset during data bit 4 of a 0xA7 frame
    frame = {1'b1, 8'hA7, 1'b0};
    $display("partial frame 0xA7, reset in bit 4 at T0=%0d", cyc + 1);
    for (int i = 0; i < 5; i++) begin
      rx = frame[i];
      idle_cycles((i == 4) ? CPB / 2 : CPB);
    end
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    rx = 1'b1;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_data", {24'd0, data}, 32'h00);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(20);
    mark();
    send_frame(8'h81, 1'b1);
    idle_cycles(4);
    check("81_valid_cnt", vcnt - vbase, 32'd1);
    check("81_data", {24'd0, data}, 32'h81);
    check("81_ferr_cnt", fcnt - fbase, 32'd0);

    check("never_both", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
